// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state type and frame constants.
// Used by both the receiver and the transmitter on the same link.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Fractional-accumulator tick generator: RATE ticks per second
// derived from a CLK_HZ clock without an integer divider.
module uart_baud_gen #(
    parameter int CLK_HZ = 100_000_000,
    parameter int RATE   = 1_843_200
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic clr,
    output logic tick
);

    localparam int AW = $clog2(CLK_HZ) + 1;
    localparam logic [AW-1:0] W_RATE = AW'(RATE);
    localparam logic [AW-1:0] W_CLK  = AW'(CLK_HZ);

    logic [AW-1:0] r_acc;
    logic [AW-1:0] w_nxt;

    assign w_nxt = r_acc + W_RATE;
    assign tick  = (w_nxt >= W_CLK);

    // Accumulate RATE per cycle, wrapping by CLK_HZ on each tick.
    always_ff @(posedge i_clk) begin
        if (!i_rstn || clr) begin
            r_acc <= '0;
        end else if (tick) begin
            r_acc <= w_nxt - W_CLK;
        end else begin
            r_acc <= w_nxt;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, 16x oversampled, mid-bit sampling.
// Emits a one-cycle valid strobe per good byte, ferr on a bad stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       sys_clk_i,
    input  logic       sys_rstn_i,
    input  logic       uart_rx_i,
    output logic [7:0] uart_dat_o,
    output logic       uart_valid_o,
    output logic       uart_ferr_o,
    output logic       uart_busy_o
);

    localparam logic [3:0] OS_MID   = 4'(UART_OVERSAMPLE / 2 - 1);
    localparam logic [3:0] OS_LAST  = 4'(UART_OVERSAMPLE - 1);
    localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);

    logic        r_sync1;
    logic        r_sync2;
    uart_state_t r_state;
    logic [3:0]  r_os_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_sh;
    logic [7:0]  r_dat;
    logic        r_valid;
    logic        r_ferr;

    logic        w_rx_s;
    logic        w_tick;
    logic        w_clr;
    logic        w_mid;
    logic        w_last;

    assign w_rx_s = r_sync2;
    assign w_clr  = (r_state == IDLE) && !w_rx_s;
    assign w_mid  = w_tick && (r_os_cnt == OS_MID);
    assign w_last = w_tick && (r_os_cnt == OS_LAST);

    // Two-flop synchronizer; idles high so reset looks like an idle line.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rstn_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx_i;
            r_sync2 <= r_sync1;
        end
    end

    // 16x bit-rate tick, re-phased to the start edge.
    uart_baud_gen #(
        .CLK_HZ (CLK_HZ),
        .RATE   (UART_OVERSAMPLE * BAUD)
    ) u_baud (
        .i_clk  (sys_clk_i),
        .i_rstn (sys_rstn_i),
        .clr    (w_clr),
        .tick   (w_tick)
    );

    // Frame FSM: start validation, data shift, stop check, break hold.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rstn_i) begin
            r_state   <= IDLE;
            r_os_cnt  <= '0;
            r_bit_idx <= '0;
            r_sh      <= '0;
            r_dat     <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state  <= START;
                        r_os_cnt <= '0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_os_cnt <= r_os_cnt + 4'd1;
                    end
                    if (w_mid) begin
                        if (!w_rx_s) begin
                            r_state   <= DATA;
                            r_os_cnt  <= '0;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_os_cnt <= r_os_cnt + 4'd1;
                    end
                    if (w_last) begin
                        r_sh <= {w_rx_s, r_sh[7:1]};
                        if (r_bit_idx == BIT_LAST) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_os_cnt <= r_os_cnt + 4'd1;
                    end
                    if (w_last) begin
                        if (w_rx_s) begin
                            r_dat   <= r_sh;
                            r_valid <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign uart_dat_o   = r_dat;
    assign uart_valid_o = r_valid;
    assign uart_ferr_o  = r_ferr;
    assign uart_busy_o  = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial stimulus on the pin,
// expected bytes queued at send time and matched on each valid strobe.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int  CLK_HZ  = 20_000_000;
    localparam int  BAUD    = 115200;
    localparam real BIT_NS  = 1.0e9 / BAUD;
    localparam int  BIT_CYC = CLK_HZ / BAUD;
    localparam int  DRAIN   = 24 * BIT_CYC;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       rx   = 1'b1;
    logic [7:0] dat;
    logic       valid;
    logic       ferr;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_ferr   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    logic [7:0] mon_exp;

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .sys_clk_i    (clk),
        .sys_rstn_i   (rstn),
        .uart_rx_i    (rx),
        .uart_dat_o   (dat),
        .uart_valid_o (valid),
        .uart_ferr_o  (ferr),
        .uart_busy_o  (busy)
    );

    always #25 clk = ~clk;

    // Scoreboard side: every valid strobe must match the oldest queued byte.
    always @(negedge clk) begin
        if (valid && ferr) begin
            n_checks++;
            n_fail++;
            $display("FAIL valid_ferr_overlap: valid=%b ferr=%b, required not both", valid, ferr);
        end
        if (valid) begin
            n_valid++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: dat=%02h, required no pulse", dat);
            end else begin
                mon_exp = exp_q.pop_front();
                if (dat !== mon_exp) begin
                    n_fail++;
                    $display("FAIL rx_byte: got %02h, required %02h", dat, mon_exp);
                end
            end
        end
        if (ferr) n_ferr++;
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic [7:0] b, input real bit_ns, input logic stop_v);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop_v;
        #(bit_ns);
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back(b);
        last_good = b;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < DRAIN) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (dat !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_dat: got %02h, required 00", dat);
        end
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b, required 0", valid);
        end
        n_checks++;
        if (ferr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ferr: got %b, required 0", ferr);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b, required 0", busy);
        end
        rstn = 1'b1;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    task automatic test_bytes();
        int v0, f0;
        v0 = n_valid;
        f0 = n_ferr;
        expect_byte(8'h55);
        send_frame(8'h55, BIT_NS, 1'b1);
        expect_byte(8'hA3);
        send_frame(8'hA3, BIT_NS, 1'b1);
        wait_drain();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL bytes_pending: got %0d, required 0", exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (n_valid !== v0 + 2) begin
            n_fail++;
            $display("FAIL bytes_count: got %0d, required %0d", n_valid - v0, 2);
        end
        n_checks++;
        if (n_ferr !== f0) begin
            n_fail++;
            $display("FAIL bytes_ferr: got %0d, required 0", n_ferr - f0);
        end
        n_checks++;
        if (dat !== 8'hA3) begin
            n_fail++;
            $display("FAIL bytes_hold: got %02h, required a3", dat);
        end
        repeat (BIT_CYC) @(negedge clk);
    endtask

    task automatic test_glitch();
        int v0, f0;
        v0 = n_valid;
        f0 = n_ferr;
        rx = 1'b0;
        #2000;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_start: busy got %b, required 1", busy);
        end
        rx = 1'b1;
        repeat (BIT_CYC) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_idle: busy got %b, required 0", busy);
        end
        n_checks++;
        if (n_valid !== v0 || n_ferr !== f0) begin
            n_fail++;
            $display("FAIL glitch_pulse: valid %0d ferr %0d, required 0 0", n_valid - v0, n_ferr - f0);
        end
    endtask

    task automatic test_framing_error();
        int v0, f0;
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(8'h3C, BIT_NS, 1'b0);
        #(3.0 * BIT_NS);
        n_checks++;
        if (n_ferr !== f0 + 1) begin
            n_fail++;
            $display("FAIL ferr_count: got %0d, required 1", n_ferr - f0);
        end
        n_checks++;
        if (n_valid !== v0) begin
            n_fail++;
            $display("FAIL ferr_valid: got %0d, required 0", n_valid - v0);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ferr_break_busy: got %b, required 1", busy);
        end
        n_checks++;
        if (dat !== last_good) begin
            n_fail++;
            $display("FAIL ferr_dat_hold: got %02h, required %02h", dat, last_good);
        end
        rx = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_break_exit: busy got %b, required 0", busy);
        end
        repeat (BIT_CYC) @(negedge clk);
        n_checks++;
        if (n_ferr !== f0 + 1) begin
            n_fail++;
            $display("FAIL ferr_repeat: got %0d, required 1", n_ferr - f0);
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = n_valid;
        expect_byte(8'h00);
        send_frame(8'h00, BIT_NS, 1'b1);
        expect_byte(8'hFF);
        send_frame(8'hFF, BIT_NS, 1'b1);
        wait_drain();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL b2b_pending: got %0d, required 0", exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (n_valid !== v0 + 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d, required 2", n_valid - v0);
        end
        n_checks++;
        if (dat !== 8'hFF) begin
            n_fail++;
            $display("FAIL b2b_dat: got %02h, required ff", dat);
        end
        repeat (BIT_CYC) @(negedge clk);
    endtask

    task automatic test_baud_tolerance();
        int v0, f0;
        v0 = n_valid;
        f0 = n_ferr;
        expect_byte(8'h96);
        send_frame(8'h96, BIT_NS / 1.03, 1'b1);
        #(BIT_NS);
        expect_byte(8'h96);
        send_frame(8'h96, BIT_NS / 0.97, 1'b1);
        wait_drain();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL baud_pending: got %0d, required 0", exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (n_valid !== v0 + 2 || n_ferr !== f0) begin
            n_fail++;
            $display("FAIL baud_count: valid %0d ferr %0d, required 2 0", n_valid - v0, n_ferr - f0);
        end
        repeat (BIT_CYC) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int v0, f0;
        v0 = n_valid;
        f0 = n_ferr;
        fork
            send_frame(8'h5A, BIT_NS, 1'b1);
            begin
                #(5.5 * BIT_NS);
                @(negedge clk);
                rstn = 1'b0;
                @(negedge clk);
                n_checks++;
                if (dat !== 8'h00 || valid !== 1'b0 || ferr !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midrst_outputs: dat=%02h valid=%b ferr=%b busy=%b, required 00 0 0 0",
                             dat, valid, ferr, busy);
                end
                rstn = 1'b1;
                last_good = 8'h00;
            end
        join
        #(0.5 * BIT_NS);
        n_checks++;
        if (n_valid !== v0 || n_ferr !== f0) begin
            n_fail++;
            $display("FAIL midrst_no_pulse: valid %0d ferr %0d, required 0 0", n_valid - v0, n_ferr - f0);
        end
        // Bit 5 of 0x5A falls after reset and starts a fresh frame:
        // 1,0 (bits 6,7), 1 (stop), then idle ones -> 0xFD.
        expect_byte(8'hFD);
        wait_drain();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL midrst_resync: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
        #(2.0 * BIT_NS);
        expect_byte(8'h81);
        send_frame(8'h81, BIT_NS, 1'b1);
        wait_drain();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL midrst_next_pending: got %0d, required 0", exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (dat !== 8'h81) begin
            n_fail++;
            $display("FAIL midrst_next_dat: got %02h, required 81", dat);
        end
        n_checks++;
        if (n_ferr !== f0) begin
            n_fail++;
            $display("FAIL midrst_ferr: got %0d, required 0", n_ferr - f0);
        end
    endtask

    initial begin
        test_reset();
        test_bytes();
        test_glitch();
        test_framing_error();
        test_back_to_back();
        test_baud_tolerance();
        test_reset_mid_frame();
        repeat (BIT_CYC) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
